// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats into one wide FIFO word; in_last flushes a partial word with a lane-valid mask.
// Latency: word presented one cycle after its completing beat; in_ready drops combinationally only while a word is stalled on fifo_full.
module fifo_wr_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [IN_WIDTH*RATIO-1:0] fifo_wr_data,
    output logic [RATIO-1:0]          fifo_wr_keep,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full,
    output logic [CNT_WIDTH-1:0]      words_written
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = $clog2(RATIO);

    logic [LANE_W-1:0]    r_lane;
    logic [OUT_WIDTH-1:0] r_acc_data;
    logic [RATIO-1:0]     r_acc_keep;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [RATIO-1:0]     r_out_keep;
    logic                 r_out_valid;
    logic [CNT_WIDTH-1:0] r_words;

    logic                 w_accept;
    logic                 w_last_lane;
    logic                 w_complete;
    logic                 w_write;
    logic [OUT_WIDTH-1:0] w_fill_data;
    logic [RATIO-1:0]     w_fill_keep;

    // in_ready depends only on registered state and fifo_full, never on in_valid
    assign in_ready    = !(r_out_valid && fifo_full);
    assign w_write     = r_out_valid && !fifo_full;
    assign w_accept    = in_valid && in_ready;
    assign w_last_lane = (r_lane == LANE_W'(RATIO - 1));
    assign w_complete  = w_accept && (w_last_lane || in_last);

    always_comb begin
        w_fill_data = r_acc_data;
        w_fill_keep = r_acc_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_fill_data[i*IN_WIDTH +: IN_WIDTH] = in_data;
                w_fill_keep[i]                      = 1'b1;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_lane     <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_lane     <= '0;
                r_acc_data <= '0;
                r_acc_keep <= '0;
            end else begin
                r_lane     <= r_lane + LANE_W'(1);
                r_acc_data <= w_fill_data;
                r_acc_keep <= w_fill_keep;
            end
        end
    end

    // A completion in the same cycle as a drain reloads the output register
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete) begin
            r_out_data  <= w_fill_data;
            r_out_keep  <= w_fill_keep;
            r_out_valid <= 1'b1;
        end else if (w_write) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_words <= '0;
        end else if (w_write) begin
            r_words <= r_words + CNT_WIDTH'(1);
        end
    end

    assign fifo_wr_en    = w_write;
    assign fifo_wr_data  = r_out_data;
    assign fifo_wr_keep  = r_out_keep;
    assign words_written = r_words;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: directed vector table, reset sequences, and randomized traffic against a queue-based packing model.
module tb_fifo_wr_packer;

    localparam int IW = 8;
    localparam int R  = 4;

    logic        wr_clk = 1'b0;
    logic        wr_rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] fifo_wr_data;
    logic [3:0]  fifo_wr_keep;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic [15:0] words_written;

    logic        in_ready4;
    logic [31:0] fifo_wr_data4;
    logic [3:0]  fifo_wr_keep4;
    logic        fifo_wr_en4;
    logic [3:0]  words_written4;

    int tests = 0;
    int fails = 0;

    fifo_wr_packer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(16)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_keep(fifo_wr_keep), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .words_written(words_written)
    );

    // Narrow-counter copy sharing the same stimulus, used for the wrap check
    fifo_wr_packer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(4)) dut4 (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready4), .fifo_wr_data(fifo_wr_data4),
        .fifo_wr_keep(fifo_wr_keep4), .fifo_wr_en(fifo_wr_en4), .fifo_full(fifo_full),
        .words_written(words_written4)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        f;
        logic        rdy;
        logic        wr;
        logic        chk;
        logic [31:0] dat;
        logic [3:0]  keep;
        logic [15:0] cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  cur[$];
    logic [31:0] exp_dat[$];
    logic [3:0]  exp_keep[$];
    int          produced;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic f,
                       input logic rdy, input logic wr, input logic c,
                       input logic [31:0] dat, input logic [3:0] keep, input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.f = f; r.rdy = rdy; r.wr = wr;
        r.chk = c; r.dat = dat; r.keep = keep; r.cnt = cnt;
        vecs.push_back(r);
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic l, input logic f);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        fifo_full = f;
        #1;
    endtask

    task automatic tick();
        @(posedge wr_clk);
        @(negedge wr_clk);
    endtask

    task automatic reset_pulse();
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        wr_rst = 1'b1;
        tick();
        wr_rst = 1'b0;
        cur.delete();
        exp_dat.delete();
        exp_keep.delete();
        produced = 0;
    endtask

    task automatic model_push(input logic [7:0] d, input logic l);
        logic [31:0] w;
        logic [3:0]  k;
        cur.push_back(d);
        if (cur.size() == R || l) begin
            w = '0;
            k = '0;
            for (int i = 0; i < cur.size(); i++) begin
                w[i*8 +: 8] = cur[i];
                k[i]        = 1'b1;
            end
            exp_dat.push_back(w);
            exp_keep.push_back(k);
            cur.delete();
            produced++;
        end
    endtask

    task automatic rcycle(input logic v, input logic [7:0] d, input logic l, input logic f,
                          output logic acc);
        logic pend;
        set_in(v, d, l, f);
        pend = (exp_dat.size() != 0);
        chk("rand_in_ready", {63'd0, in_ready}, {63'd0, !(pend && f)});
        chk("rand_wr_en", {63'd0, fifo_wr_en}, {63'd0, pend && !f});
        if (fifo_wr_en && pend) begin
            chk("rand_wr_data", {32'd0, fifo_wr_data}, {32'd0, exp_dat.pop_front()});
            chk("rand_wr_keep", {60'd0, fifo_wr_keep}, {60'd0, exp_keep.pop_front()});
        end
        acc = v && in_ready;
        if (acc) model_push(d, l);
        tick();
    endtask

    task automatic random_run(input int nbeats, input int last_pct);
        int          idx;
        int          cyc;
        logic        acc;
        logic        v;
        logic        f;
        logic        l;
        logic [7:0]  d;
        idx = 0;
        cyc = 0;
        d   = 8'($urandom);
        l   = ($urandom_range(0, 99) < last_pct);
        while (idx < nbeats && cyc < 3000) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 2) == 0);
            rcycle(v, d, l, f, acc);
            if (acc) begin
                idx++;
                d = 8'($urandom);
                l = ($urandom_range(0, 99) < last_pct);
            end
            cyc++;
        end
        chk("rand_all_beats_accepted", 64'(idx), 64'(nbeats));
        cyc = 0;
        while (exp_dat.size() != 0 && cyc < 50) begin
            rcycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
            cyc++;
        end
        chk("rand_drained", 64'(exp_dat.size()), 64'd0);
        rcycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        wr_rst    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        produced  = 0;
        @(negedge wr_clk);
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_wr_en", {63'd0, fifo_wr_en}, 64'd0);
        chk("reset_wr_data", {32'd0, fifo_wr_data}, 64'd0);
        chk("reset_wr_keep", {60'd0, fifo_wr_keep}, 64'd0);
        chk("reset_words", {48'd0, words_written}, 64'd0);
        wr_rst = 1'b0;

        // Directed table: full word, partial flush, 10-cycle stall, idle last, reload, last on lane 3
        add(1, 8'h11, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 8'h22, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 8'h33, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 8'h44, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 1, 1, 32'h44332211, 4'hF, 0);
        add(1, 8'hA1, 0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 8'hA2, 1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 1, 1, 1, 32'h0000A2A1, 4'h3, 1);
        add(1, 8'hB1, 0, 0, 1, 0, 0, 0, 0, 2);
        add(1, 8'hB2, 0, 0, 1, 0, 0, 0, 0, 2);
        add(1, 8'hB3, 0, 0, 1, 0, 0, 0, 0, 2);
        add(1, 8'hB4, 0, 0, 1, 0, 0, 0, 0, 2);
        add(0, 8'h00, 0, 1, 0, 0, 1, 32'hB4B3B2B1, 4'hF, 2);
        for (int i = 0; i < 9; i++) add(1, 8'hC1, 0, 1, 0, 0, 1, 32'hB4B3B2B1, 4'hF, 2);
        add(1, 8'hC1, 0, 0, 1, 1, 1, 32'hB4B3B2B1, 4'hF, 2);
        add(1, 8'hC2, 1, 0, 1, 0, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 1, 1, 1, 32'h0000C2C1, 4'h3, 3);
        add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 4);
        add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 4);
        add(1, 8'hD1, 1, 0, 1, 0, 0, 0, 0, 4);
        add(1, 8'hE1, 1, 0, 1, 1, 1, 32'h000000D1, 4'h1, 4);
        add(0, 8'h00, 0, 0, 1, 1, 1, 32'h000000E1, 4'h1, 5);
        add(1, 8'hF1, 0, 0, 1, 0, 0, 0, 0, 6);
        add(1, 8'hF2, 0, 0, 1, 0, 0, 0, 0, 6);
        add(1, 8'hF3, 0, 0, 1, 0, 0, 0, 0, 6);
        add(1, 8'hF4, 1, 0, 1, 0, 0, 0, 0, 6);
        add(0, 8'h00, 0, 0, 1, 1, 1, 32'hF4F3F2F1, 4'hF, 6);
        add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 7);
        add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 7);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f);
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].rdy});
            chk($sformatf("vec%0d_wr_en", i), {63'd0, fifo_wr_en}, {63'd0, vecs[i].wr});
            chk($sformatf("vec%0d_words", i), {48'd0, words_written}, {48'd0, vecs[i].cnt});
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_wr_data", i), {32'd0, fifo_wr_data}, {32'd0, vecs[i].dat});
                chk($sformatf("vec%0d_wr_keep", i), {60'd0, fifo_wr_keep}, {60'd0, vecs[i].keep});
            end
            tick();
        end

        // 64 full-width beats with gaps and full toggling: 16 words, narrow counter wraps to 0
        reset_pulse();
        random_run(64, 0);
        chk("rand64_words", {48'd0, words_written}, 64'd16);
        chk("rand64_words_cnt4_wrap", {60'd0, words_written4}, 64'd0);

        reset_pulse();
        random_run(120, 20);
        chk("rand_last_words", {48'd0, words_written}, 64'(produced % 65536));
        chk("rand_last_words_cnt4", {60'd0, words_written4}, 64'(produced % 16));

        // Reset mid-word: partial beats are discarded, next word starts at lane 0
        reset_pulse();
        set_in(1, 8'h55, 0, 0); tick();
        set_in(1, 8'h66, 0, 0); tick();
        in_valid = 1'b0;
        #2;
        wr_rst = 1'b1;
        #1;
        chk("rstA_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rstA_wr_en", {63'd0, fifo_wr_en}, 64'd0);
        chk("rstA_wr_data", {32'd0, fifo_wr_data}, 64'd0);
        chk("rstA_wr_keep", {60'd0, fifo_wr_keep}, 64'd0);
        chk("rstA_words", {48'd0, words_written}, 64'd0);
        tick();
        wr_rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 8'(i), 0, 0);
            chk($sformatf("rstA_beat%0d_no_write", i), {63'd0, fifo_wr_en}, 64'd0);
            tick();
        end
        set_in(0, 8'h00, 0, 0);
        chk("rstA_word_wr_en", {63'd0, fifo_wr_en}, 64'd1);
        chk("rstA_word_data", {32'd0, fifo_wr_data}, 64'h04030201);
        chk("rstA_word_keep", {60'd0, fifo_wr_keep}, 64'hF);
        tick();
        set_in(0, 8'h00, 0, 0);
        chk("rstA_word_count", {48'd0, words_written}, 64'd1);

        // Reset while stalled: pending word is dropped, no write after full clears
        for (int i = 7; i <= 10; i++) begin
            set_in(1, 8'(i), 0, 0);
            tick();
        end
        set_in(0, 8'h00, 0, 1);
        chk("rstB_stalled_ready", {63'd0, in_ready}, 64'd0);
        chk("rstB_stalled_wr_en", {63'd0, fifo_wr_en}, 64'd0);
        chk("rstB_stalled_data", {32'd0, fifo_wr_data}, 64'h0A090807);
        #1;
        wr_rst = 1'b1;
        #1;
        chk("rstB_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rstB_wr_en", {63'd0, fifo_wr_en}, 64'd0);
        chk("rstB_wr_data", {32'd0, fifo_wr_data}, 64'd0);
        chk("rstB_wr_keep", {60'd0, fifo_wr_keep}, 64'd0);
        chk("rstB_words", {48'd0, words_written}, 64'd0);
        tick();
        wr_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 8'h00, 0, 0);
            chk($sformatf("rstB_idle%0d_no_write", i), {63'd0, fifo_wr_en}, 64'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side packer that sits directly upstream of the async FIFO in the `wr_clk` domain. It accepts a narrow valid/ready byte stream, packs `RATIO` consecutive beats into one wide word, and writes that word into the FIFO's write port under `full` back-pressure. A frame-end marker (`in_last`) flushes a partially filled word early; a lane-valid mask tells the read side which lanes of that word are meaningful.

## Interface
- `IN_WIDTH`, default 8: width of one input beat.
- `RATIO`, default 4: beats per packed word, ≥2. `OUT_WIDTH = IN_WIDTH*RATIO`.
- `CNT_WIDTH`, default 16: width of the word statistics counter.

Ports (one clock; reset is asynchronous and active-high):
- `wr_clk`  in  1  write-domain clock; all state on rising edge.
- `wr_rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  IN_WIDTH  input beat payload.
- `in_valid`  in  1  input beat present.
- `in_last`  in  1  beat ends a frame; flush the word after this beat.
- `in_ready`  out  1  packer can accept a beat this cycle.
- `fifo_wr_data`  out  OUT_WIDTH  packed word to the FIFO; lane 0 is `[IN_WIDTH-1:0]`.
- `fifo_wr_keep`  out  RATIO  lane-valid mask for `fifo_wr_data`; stored alongside the data.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_full`  in  1  FIFO `full` flag, `wr_clk` domain.
- `words_written`  out  CNT_WIDTH  count of words written to the FIFO; wraps.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge.
- Accumulator: `acc_data` is `OUT_WIDTH` bits, `acc_keep` is `RATIO` bits, and `lane` is a counter over `0..RATIO-1`.
- An accepted beat writes `acc_data` lane `lane` and sets `acc_keep[lane]`.
- Lanes fill in arrival order. The first beat of a word goes to lane 0.
- Completion: an accepted beat completes the word when `lane == RATIO-1` or `in_last == 1`. On completion:
  - `{acc_data, acc_keep}` including the current beat is copied to the output register and `out_valid` is set.
  - `lane`, `acc_data` and `acc_keep` return to 0.
- Unused lanes of a flushed partial word are zero, with keep bit 0.
- Non-completing accept: `lane` increments by 1.
- Output stage:
  - `fifo_wr_en = out_valid && !fifo_full` (combinational).
  - `fifo_wr_data` and `fifo_wr_keep` are driven from the output register and are stable while `out_valid` is set.
  - When `fifo_wr_en` is high, `out_valid` clears on the next edge, unless a completion happens in the same cycle; then it reloads with the new word.
- Back-pressure: `in_ready = !(out_valid && fifo_full)`. `in_ready` never depends on `in_valid` or the payload.
- `words_written` increments on every `fifo_wr_en`, modulo 2^CNT_WIDTH.
- State view:
  - FILL: `out_valid = 0`.
  - PENDING: `out_valid = 1`, FIFO not full, drains this cycle.
  - STALLED: `out_valid = 1`, `fifo_full = 1`, `in_ready = 0`.
  - STALLED returns to PENDING when `full` deasserts.
- Boundaries:
  - `in_last` on lane `RATIO-1` produces one full word with `keep` all ones, not an extra empty word.
  - `in_last` on lane 0 produces `keep = 0b0001`.
  - The packer never generates an all-zero-keep word.
  - `fifo_full` rising while `out_valid` is set holds the word; the write never occurs while full.
  - An idle `in_last` without `in_valid` is ignored.
- Reset (asserted at any time, including mid-word or while stalled):
  - Clears `lane`, `acc_*`, `out_valid` and `words_written`.
  - A partial word and any pending word are discarded; no write is issued.

## Timing
- Reset values:
  - `in_ready = 1`.
  - `fifo_wr_en = 0`.
  - `fifo_wr_data = 0`.
  - `fifo_wr_keep = 0`.
  - `words_written = 0`.
- Latency: a beat completing a word at edge N gives `out_valid = 1` after N. With FIFO not full, `fifo_wr_en` is high in cycle N+1 and the write happens at edge N+1.
- Throughput: one beat per cycle sustained with FIFO not full, which is one word every `RATIO` cycles.
- `fifo_full` to `in_ready` is combinational, with zero-cycle reaction.
- No combinational path from `in_valid` to `in_ready`.

## Test plan
- Reset, then stream bytes 0x11,0x22,0x33,0x44 back-to-back (RATIO=4) → one write, `fifo_wr_data = 0x44332211`, keep `0xF`, `words_written = 1`, `in_ready` constantly 1.
- Bytes 0xA1,0xA2 with `in_last` on 0xA2 → `fifo_wr_data = 0x0000A2A1`, keep `0x3`. The next 4 bytes form a fresh word starting at lane 0.
- `fifo_full = 1` for 10 cycles while a completed word is pending → `fifo_wr_en = 0`, `in_ready = 0`, data and keep stable. After `full` drops: exactly one write, then normal flow resumes with no beat lost or duplicated.
- 64 random bytes with random `in_valid` gaps and random `fifo_full` toggling → the scoreboard of written words equals the packed input sequence; `words_written = 16`.
- Assert `wr_rst` asynchronously after 2 beats of a word and while a word is pending → all outputs at reset values immediately, no write emitted, next 4 bytes produce a word with lane 0 = first new byte.
- Preload `words_written` near wrap (CNT_WIDTH=4, 16 words) → counter reads 0 after the 16th write.
